uart_wrapper: RTL and testbench

Byte-to-command framing stage directly upstream of the quadcopter command configuration unit. Accepts 8-bit bytes from the BLE UART transceiver and assembles them into 24-bit commands (opcode byte followed by a 16-bit data word, high byte first), presenting `cmd`/`data` with a `cmd_rdy` flag. Serialises the 8-bit response byte back to the transceiver. Includes an inter-byte gap timer that discards partial frames after a stalled link.

---
 rtl/uart_wrapper.sv | 172 +++++++++++++++++
 tb/tb_uart_wrapper.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wrapper.sv
// Byte-to-command framing between the BLE UART transceiver and the command unit:
// assembles opcode + 16-bit data frames and serialises response bytes back out.
module uart_wrapper #(
  parameter int GAP_WIDTH = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_err,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        resp_drop,
  output logic [1:0]  dbg_rx_state
);

  // Handshake: rx_rdy is a level held by the transceiver until clr_rx_rdy pulses
  // in the same cycle the byte is captured; cmd_rdy holds until clr_cmd_rdy.
  typedef enum logic [1:0] {
    RX_CMD = 2'd0,
    RX_DHI = 2'd1,
    RX_DLO = 2'd2
  } rx_state_e;

  rx_state_e            state_q, state_d;
  logic [GAP_WIDTH-1:0] gap_q, gap_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [15:0]          data_q, data_d;
  logic                 cmd_rdy_q, cmd_rdy_d;
  logic                 frame_err_q, frame_err_d;
  logic                 accept;

  logic                 busy_q, busy_d;
  logic [7:0]           pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 trmt_q, trmt_d;
  logic                 drop_q, drop_d;

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q + GAP_WIDTH'(1);
    cmd_d       = cmd_q;
    data_d      = data_q;
    cmd_rdy_d   = cmd_rdy_q;
    frame_err_d = 1'b0;
    accept      = 1'b0;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    case (state_q)
      RX_CMD: begin
        gap_d = '0;
        // A held command back-pressures the next opcode byte.
        if (rx_rdy && !cmd_rdy_q) begin
          accept  = 1'b1;
          cmd_d   = rx_data;
          state_d = RX_DHI;
        end
      end
      RX_DHI: begin
        if (rx_rdy) begin
          accept        = 1'b1;
          data_d[15:8]  = rx_data;
          gap_d         = '0;
          state_d       = RX_DLO;
        end else if (&gap_q) begin
          frame_err_d = 1'b1;
          gap_d       = '0;
          state_d     = RX_CMD;
        end
      end
      RX_DLO: begin
        if (rx_rdy) begin
          accept       = 1'b1;
          data_d[7:0]  = rx_data;
          cmd_rdy_d    = 1'b1;
          gap_d        = '0;
          state_d      = RX_CMD;
        end else if (&gap_q) begin
          frame_err_d = 1'b1;
          gap_d       = '0;
          state_d     = RX_CMD;
        end
      end
      default: state_d = RX_CMD;
    endcase
  end

  always_comb begin
    busy_d     = busy_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    tx_data_d  = tx_data_q;
    trmt_d     = 1'b0;
    drop_d     = 1'b0;
    if (!busy_q) begin
      if (send_resp) begin
        tx_data_d = resp;
        trmt_d    = 1'b1;
        busy_d    = 1'b1;
      end
    end else if (tx_done) begin
      // Completion frees a slot first, so a coincident request is never dropped.
      if (pend_vld_q) begin
        tx_data_d = pend_q;
        trmt_d    = 1'b1;
        if (send_resp) pend_d = resp;
        else           pend_vld_d = 1'b0;
      end else if (send_resp) begin
        tx_data_d = resp;
        trmt_d    = 1'b1;
      end else begin
        busy_d = 1'b0;
      end
    end else if (send_resp) begin
      if (!pend_vld_q) begin
        pend_d     = resp;
        pend_vld_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RX_CMD;
      gap_q       <= '0;
      cmd_q       <= 8'h00;
      data_q      <= 16'h0000;
      cmd_rdy_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      pend_q      <= 8'h00;
      pend_vld_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      trmt_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      cmd_rdy_q   <= cmd_rdy_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      tx_data_q   <= tx_data_d;
      trmt_q      <= trmt_d;
      drop_q      <= drop_d;
    end
  end

  assign clr_rx_rdy   = accept;
  assign cmd          = cmd_q;
  assign data         = data_q;
  assign cmd_rdy      = cmd_rdy_q;
  assign frame_err    = frame_err_q;
  assign trmt         = trmt_q;
  assign tx_data      = tx_data_q;
  assign resp_drop    = drop_q;
  assign dbg_rx_state = state_q;

endmodule

// File: tb/tb_uart_wrapper.sv
// Randomised scoreboard bench for uart_wrapper: byte-frame and response-queue
// reference models push expectations; a monitor pops them on DUT output events.
module tb_uart_wrapper;
  localparam int GW  = 6;
  localparam int SAT = (1 << GW);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rdy, clr_rx_rdy, cmd_rdy, clr_cmd_rdy, frame_err;
  logic [7:0]  rx_data, cmd, resp, tx_data;
  logic [15:0] data;
  logic        send_resp, trmt, tx_done, resp_drop;
  logic [1:0]  dbg_rx_state;

  uart_wrapper #(.GAP_WIDTH(GW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .data(data), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .frame_err(frame_err), .resp(resp),
    .send_resp(send_resp), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
    .resp_drop(resp_drop), .dbg_rx_state(dbg_rx_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Scoreboard expectations
  logic [23:0] exp_cmd_q[$];
  logic [7:0]  exp_tx_q[$];
  int          exp_ferr = 0;
  int          exp_drop = 0;

  // Reference model state: bytes of the frame being assembled, bytes owned by the transmitter
  logic [7:0]  frame[$];
  logic [7:0]  txq[$];
  int          last_acc = 0;
  logic        cons_en = 1'b0;
  logic        spur_en = 1'b0;
  logic [23:0] last_cmd = '0;
  logic        rdy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=0x%0h expected=no event t=%0t", name, act, $time);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("clr_without_rx", {31'd0, clr_rx_rdy & ~rx_rdy}, 32'd0);
        if (cmd_rdy && !rdy_prev) begin
          if (exp_cmd_q.size() == 0) unexpected("cmd_unexpected", {8'd0, cmd, data});
          else begin
            last_cmd = exp_cmd_q.pop_front();
            check("cmd_frame", {8'd0, cmd, data}, {8'd0, last_cmd});
          end
        end else if (cmd_rdy) begin
          check("cmd_hold", {8'd0, cmd, data}, {8'd0, last_cmd});
        end
        if (trmt) begin
          if (exp_tx_q.size() == 0) unexpected("trmt_unexpected", {24'd0, tx_data});
          else check("tx_data", {24'd0, tx_data}, {24'd0, exp_tx_q.pop_front()});
        end
        if (frame_err) begin
          if (exp_ferr == 0) unexpected("frame_err_unexpected", 32'd1);
          else begin checks++; exp_ferr--; end
        end
        if (resp_drop) begin
          if (exp_drop == 0) unexpected("resp_drop_unexpected", 32'd1);
          else begin checks++; exp_drop--; end
        end
      end
      rdy_prev = cmd_rdy;
    end
  end

  // Command consumer
  initial begin
    clr_cmd_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (cons_en && cmd_rdy && rst_n) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b1;
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
        check("cmd_rdy_clear", {31'd0, cmd_rdy}, 32'd0);
      end else if (spur_en && $urandom_range(0, 19) == 0) begin
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b1;
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b0;
      end
    end
  end

  // Present one byte after g idle cycles; the model decides from the elapsed
  // cycles since the previous accepted byte whether the partial frame expired.
  task automatic send_byte(input logic [7:0] b, input int g);
    int  p;
    bit  ok;
    p = cyc + g;
    if (frame.size() > 0 && (p - last_acc) >= SAT) begin
      exp_ferr++;
      frame.delete();
    end
    repeat (g) begin @(posedge clk); #1; end
    rx_data = b;
    rx_rdy  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (clr_rx_rdy) ok = 1'b1;
    end
    if (!ok) begin
      unexpected("rx_accept_timeout", {24'd0, b});
      rx_rdy = 1'b0;
      return;
    end
    @(posedge clk); #1;
    rx_rdy   = 1'b0;
    last_acc = cyc;
    frame.push_back(b);
    if (frame.size() == 3) begin
      exp_cmd_q.push_back({frame[0], frame[1], frame[2]});
      frame.delete();
    end
  endtask

  // One transmit-side cycle; the model sees the transmitter as a two-deep byte queue.
  task automatic tx_cycle(input logic done, input logic send, input logic [7:0] r);
    tx_done   = done;
    send_resp = send;
    resp      = r;
    if (done && txq.size() > 0) begin
      void'(txq.pop_front());
      if (txq.size() > 0) exp_tx_q.push_back(txq[0]);
    end
    if (send) begin
      if (txq.size() < 2) begin
        txq.push_back(r);
        if (txq.size() == 1) exp_tx_q.push_back(r);
      end else begin
        exp_drop++;
      end
    end
    @(posedge clk); #1;
    tx_done   = 1'b0;
    send_resp = 1'b0;
  endtask

  task automatic rx_thread();
    logic [7:0] b;
    int         g;
    cons_en = 1'b0;
    send_byte(8'h02, 0);
    send_byte(8'h12, 5);
    send_byte(8'h34, 5);
    @(negedge clk);
    check("cmd_rdy_set", {31'd0, cmd_rdy}, 32'd1);
    check("cmd_value", {24'd0, cmd}, 32'h02);
    check("data_value", {16'd0, data}, 32'h1234);
    rx_data = 8'h05;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("bp_no_clr", {31'd0, clr_rx_rdy}, 32'd0);
      check("bp_cmd_hold", {24'd0, cmd}, 32'h02);
    end
    cons_en = 1'b1;
    send_byte(8'h05, 0);
    @(negedge clk);
    check("cmd_after_bp", {24'd0, cmd}, 32'h05);
    @(posedge clk); #1;
    send_byte(8'h9A, 1);
    send_byte(8'hBC, 1);
    // Stalled link, then a clean frame
    send_byte(8'h03, 3);
    send_byte(8'hAA, 2);
    send_byte(8'h04, SAT + 6);
    send_byte(8'h00, 1);
    send_byte(8'h10, 1);
    // Byte arriving in the saturation cycle, then one a cycle too late
    send_byte(8'h07, 2);
    send_byte(8'h55, SAT - 1);
    send_byte(8'h66, SAT);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    spur_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      g = ($urandom_range(0, 9) == 0) ? int'($urandom_range(SAT - 2, SAT + 2))
                                      : int'($urandom_range(0, 4));
      send_byte(b, g);
    end
    while (frame.size() != 0) send_byte(8'($urandom), 0);
    spur_en = 1'b0;
  endtask

  task automatic tx_thread();
    int   cnt;
    logic d;
    tx_cycle(1'b0, 1'b1, 8'hA5);
    tx_cycle(1'b0, 1'b0, 8'h00);
    tx_cycle(1'b0, 1'b1, 8'h3C);
    tx_cycle(1'b0, 1'b1, 8'h7E);
    tx_cycle(1'b0, 1'b0, 8'h00);
    tx_cycle(1'b1, 1'b0, 8'h00);
    tx_cycle(1'b0, 1'b0, 8'h00);
    tx_cycle(1'b1, 1'b0, 8'h00);
    // Coincident completion and request, with pending empty then full
    tx_cycle(1'b0, 1'b1, 8'h11);
    tx_cycle(1'b1, 1'b1, 8'h22);
    tx_cycle(1'b0, 1'b1, 8'h33);
    tx_cycle(1'b1, 1'b1, 8'h44);
    tx_cycle(1'b0, 1'b1, 8'h55);
    tx_cycle(1'b1, 1'b0, 8'h00);
    tx_cycle(1'b1, 1'b0, 8'h00);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      d = 1'b0;
      if (trmt) cnt = int'($urandom_range(1, 6));
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) d = 1'b1;
      end
      tx_cycle(d, (i < 370) && ($urandom_range(0, 2) == 0), 8'($urandom));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rx_rdy = 1'b0; rx_data = 8'h00; resp = 8'h00; send_resp = 1'b0; tx_done = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_cmd", {24'd0, cmd}, 32'd0);
    check("rst_data", {16'd0, data}, 32'd0);
    check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("rst_trmt", {31'd0, trmt}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_pulses", {30'd0, frame_err, resp_drop}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    fork
      rx_thread();
      tx_thread();
    join

    // Reset mid-frame with a response pending
    repeat (20) begin @(posedge clk); #1; end
    send_byte(8'h09, 0);
    send_byte(8'h11, 1);
    tx_cycle(1'b0, 1'b1, 8'h5A);
    tx_cycle(1'b0, 1'b0, 8'h00);
    tx_cycle(1'b0, 1'b1, 8'h77);
    rst_n = 1'b0;
    frame.delete();
    txq.delete();
    @(negedge clk);
    check("mid_rst_cmd", {24'd0, cmd}, 32'd0);
    check("mid_rst_data", {16'd0, data}, 32'd0);
    check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("mid_rst_flags", {28'd0, cmd_rdy, trmt, frame_err, resp_drop}, 32'd0);
    check("mid_rst_clr_rx", {31'd0, clr_rx_rdy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tx_cycle(1'b1, 1'b0, 8'h00);
    tx_cycle(1'b0, 1'b0, 8'h00);
    tx_cycle(1'b0, 1'b0, 8'h00);
    send_byte(8'h0B, 0);
    send_byte(8'h0C, 0);
    send_byte(8'h0D, 0);
    tx_cycle(1'b0, 1'b1, 8'hC3);
    tx_cycle(1'b0, 1'b0, 8'h00);
    tx_cycle(1'b1, 1'b0, 8'h00);
    repeat (12) begin @(posedge clk); #1; end

    check("cmd_queue_drained", exp_cmd_q.size(), 32'd0);
    check("tx_queue_drained", exp_tx_q.size(), 32'd0);
    check("frame_err_seen", exp_ferr, 32'd0);
    check("resp_drop_seen", exp_drop, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
